// File: rtl/cmd_frame_parser.sv
// Framing stage: hunts HEADER/LEN/payload/checksum frames from the UART receive
// port, buffers the payload and forwards it to the request FIFO only once the checksum passes.
module cmd_frame_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_ack,
  output logic [7:0] out_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
  // idle_q is still 0 on the cycle after a consume, so expiry is decided two
  // counts early to land frame_err exactly TIMEOUT_CYC cycles after the byte.
  localparam logic [IDLE_W-1:0] IDLE_EXP = IDLE_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              ack_q, guard_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  rd_nxt;
  logic [7:0]        csum_q, csum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_vld_q, out_vld_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        mem_q [2**AW];

  logic consume;
  logic counting;
  logic timeout;
  logic wr_en;

  assign consume  = rx_rdy && (state_q != S_DRAIN) && !ack_q && !guard_q;
  assign counting = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign timeout  = counting && !consume && (idle_q >= IDLE_EXP);
  assign wr_en    = consume && (state_q == S_PAYLOAD);
  assign rd_nxt   = rd_ptr_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    csum_d     = csum_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    if (consume) begin
      idle_d = '0;
    end else if (counting) begin
      idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
    end else begin
      idle_d = '0;
    end

    case (state_q)
      S_HUNT: begin
        if (consume && (rx_data == HEADER)) state_d = S_LEN;
      end
      S_LEN: begin
        if (consume) begin
          if ((rx_data == '0) || (rx_data > 8'(MAX_LEN))) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_HUNT;
          end else begin
            len_d   = CNT_W'(rx_data);
            csum_d  = rx_data;
            count_d = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (consume) begin
          csum_d  = csum_q + rx_data;
          count_d = count_q + CNT_W'(1);
          if (count_q == len_q - CNT_W'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (consume) begin
          if (rx_data == csum_q) begin
            ok_d       = 1'b1;
            rd_ptr_d   = '0;
            out_data_d = mem_q[0];
            out_vld_d  = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        if (out_vld_q && out_rdy) begin
          if (rd_ptr_q == len_q - CNT_W'(1)) begin
            out_vld_d = 1'b0;
            state_d   = S_HUNT;
          end else begin
            rd_ptr_d   = rd_nxt;
            out_data_d = mem_q[rd_nxt[AW-1:0]];
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      state_d = S_HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      ack_q      <= 1'b0;
      guard_q    <= 1'b0;
      count_q    <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= consume;
      guard_q    <= ack_q;
      count_q    <= count_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= rx_data;
  end

  assign rx_ack    = ack_q;
  assign out_data  = out_data_q;
  assign out_vld   = out_vld_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: table of frames with hand-computed results,
// plus timeout, back-pressure and reset-mid-drain sequences.
module tb_cmd_frame_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  cmd_frame_parser #(
    .HEADER     (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .rx_ack   (rx_ack),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // monitor state
  int         n_ack, n_ok, n_err, n_stall, gap_viol, hold_viol, drain_ack;
  int         last_ack_cyc, ok_cyc, err_cyc, first_vld_cyc, last_xfer_cyc;
  logic [7:0] outq[$];
  logic       prev_vld, prev_rdy;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_ack) begin
        if (cyc - last_ack_cyc < 3) gap_viol++;
        if (out_vld && prev_vld) drain_ack++;
        last_ack_cyc = cyc;
        n_ack++;
      end
      if (frame_ok) begin n_ok++; ok_cyc = cyc; end
      if (frame_err) begin n_err++; err_cyc = cyc; end
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_vld && !out_rdy) n_stall++;
      if (prev_vld && !prev_rdy && out_vld && out_data != prev_data) hold_viol++;
      if (out_vld && out_rdy) begin
        outq.push_back(out_data);
        last_xfer_cyc = cyc;
      end
    end
    prev_vld  = out_vld;
    prev_rdy  = out_rdy;
    prev_data = out_data;
  end

  task automatic clear_mon();
    n_ack = 0; n_ok = 0; n_err = 0; n_stall = 0;
    gap_viol = 0; hold_viol = 0; drain_ack = 0;
    last_ack_cyc = -100; ok_cyc = -1; err_cyc = -1;
    first_vld_cyc = -1; last_xfer_cyc = -1;
    outq.delete();
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int got;
    got = 0;
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rx_ack) begin got = 1; break; end
    end
    check("rx_ack seen", got, 1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && !out_vld) begin ok = 1; break; end
    end
    check("return to idle", ok, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int                 n;
    logic [0:19][7:0]   b;
    int                 n_ok;
    int                 n_err;
    logic [1:0]         code;
    int                 n_out;
    logic [0:15][7:0]   o;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < NV; v++) begin
      vt[v].b = '0;
      vt[v].o = '0;
    end
    vt[0].n = 6; vt[0].b[0:5] = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    vt[0].n_ok = 1; vt[0].n_err = 0; vt[0].code = 2'b00;
    vt[0].n_out = 3; vt[0].o[0:2] = {8'h11, 8'h22, 8'h33};

    vt[1].n = 6; vt[1].b[0:5] = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    vt[1].n_ok = 1; vt[1].n_err = 0; vt[1].code = 2'b00;
    vt[1].n_out = 1; vt[1].o[0] = 8'h7E;

    vt[2].n = 6; vt[2].b[0:5] = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    vt[2].n_ok = 0; vt[2].n_err = 1; vt[2].code = 2'b10; vt[2].n_out = 0;

    vt[3] = vt[0];
    vt[3].code = 2'b10;

    vt[4].n = 2; vt[4].b[0:1] = {8'hA5, 8'h00};
    vt[4].n_ok = 0; vt[4].n_err = 1; vt[4].code = 2'b01; vt[4].n_out = 0;

    vt[5].n = 2; vt[5].b[0:1] = {8'hA5, 8'h11};
    vt[5].n_ok = 0; vt[5].n_err = 1; vt[5].code = 2'b01; vt[5].n_out = 0;

    // LEN = MAX_LEN, payload 01..10: sum 0x88 + LEN 0x10 = 0x98
    vt[6].n = 19; vt[6].b[0] = 8'hA5; vt[6].b[1] = 8'h10; vt[6].b[18] = 8'h98;
    for (int i = 0; i < 16; i++) begin
      vt[6].b[2+i] = 8'(i + 1);
      vt[6].o[i]   = 8'(i + 1);
    end
    vt[6].n_ok = 1; vt[6].n_err = 0; vt[6].code = 2'b01; vt[6].n_out = 16;

    vt[7].n = 5; vt[7].b[0:4] = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
    vt[7].n_ok = 1; vt[7].n_err = 0; vt[7].code = 2'b01;
    vt[7].n_out = 2; vt[7].o[0:1] = {8'hA5, 8'hA5};

    vt[8].n = 4; vt[8].b[0:3] = {8'hA5, 8'h01, 8'hA4, 8'hA5};
    vt[8].n_ok = 1; vt[8].n_err = 0; vt[8].code = 2'b01;
    vt[8].n_out = 1; vt[8].o[0] = 8'hA4;

    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; out_rdy = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset outputs", int'({rx_ack, out_data, out_vld, frame_ok, frame_err, err_code, busy}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;

    for (int v = 0; v < NV; v++) begin
      clear_mon();
      for (int i = 0; i < vt[v].n; i++) send(vt[v].b[i]);
      wait_idle();
      check($sformatf("v%0d frame_ok count", v), n_ok, vt[v].n_ok);
      check($sformatf("v%0d frame_err count", v), n_err, vt[v].n_err);
      check($sformatf("v%0d err_code", v), int'(err_code), int'(vt[v].code));
      check($sformatf("v%0d rx_ack count", v), n_ack, vt[v].n);
      check($sformatf("v%0d ack spacing", v), gap_viol, 0);
      check($sformatf("v%0d output count", v), outq.size(), vt[v].n_out);
      for (int i = 0; i < vt[v].n_out; i++)
        check($sformatf("v%0d out byte %0d", v, i), (i < outq.size()) ? int'(outq[i]) : -1,
              int'(vt[v].o[i]));
      if (vt[v].n_ok > 0) begin
        check($sformatf("v%0d frame_ok with csum ack", v), ok_cyc - last_ack_cyc, 0);
        check($sformatf("v%0d out_vld with frame_ok", v), first_vld_cyc - ok_cyc, 0);
        check($sformatf("v%0d drain back-to-back", v), last_xfer_cyc - first_vld_cyc, vt[v].n_out - 1);
      end else begin
        check($sformatf("v%0d frame_err with last ack", v), err_cyc - last_ack_cyc, 0);
        check($sformatf("v%0d no out_vld", v), first_vld_cyc, -1);
      end
    end

    // timeout: silence after A5 02 11
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h11);
    for (int k = 0; k < 300 && n_err == 0; k++) @(negedge clk);
    check("timeout frame_err count", n_err, 1);
    check("timeout latency", err_cyc - last_ack_cyc, 99);
    check("timeout err_code", int'(err_code), 3);
    @(negedge clk);
    check("timeout busy low", int'(busy), 0);
    check("timeout no output", outq.size(), 0);
    check("timeout no frame_ok", n_ok, 0);

    // back-to-back frames with a 10-cycle stall mid-drain
    clear_mon();
    fork
      begin
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        send(8'hA5); send(8'h02); send(8'h0A); send(8'h0B); send(8'h17);
      end
      begin
        int seen;
        seen = 0;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (out_vld) begin seen = 1; break; end
        end
        check("stall: first out_vld", seen, 1);
        @(posedge clk); #1; out_rdy = 1'b0;
        repeat (10) @(posedge clk);
        #1; out_rdy = 1'b1;
      end
    join
    wait_idle();
    check("stall frame_ok count", n_ok, 2);
    check("stall frame_err count", n_err, 0);
    check("stall cycles", n_stall, 10);
    check("stall out_data held", hold_viol, 0);
    check("stall no ack in drain", drain_ack, 0);
    check("stall rx_ack count", n_ack, 11);
    check("stall output count", outq.size(), 5);
    begin
      logic [0:4][7:0] exp_o;
      exp_o = {8'h11, 8'h22, 8'h33, 8'h0A, 8'h0B};
      for (int i = 0; i < 5; i++)
        check($sformatf("stall out byte %0d", i), (i < outq.size()) ? int'(outq[i]) : -1, int'(exp_o[i]));
    end

    // reset asserted while a drain is stalled
    clear_mon();
    out_rdy = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    repeat (3) @(negedge clk);
    check("pre-reset out_vld", int'(out_vld), 1);
    check("pre-reset out_data", int'(out_data), 'h11);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({rx_ack, out_data, out_vld, frame_ok, frame_err, err_code, busy}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    check("post-reset busy", int'(busy), 0);
    check("post-reset no frame_err", n_err, 0);
    @(posedge clk); #1; out_rdy = 1'b1;
    send(8'hA5); send(8'h02); send(8'h0A); send(8'h0B); send(8'h17);
    wait_idle();
    check("post-reset frame_ok", n_ok, 1);
    check("post-reset output count", outq.size(), 2);
    check("post-reset out byte 0", (outq.size() > 0) ? int'(outq[0]) : -1, 'h0A);
    check("post-reset out byte 1", (outq.size() > 1) ? int'(outq[1]) : -1, 'h0B);
    check("post-reset err_code", int'(err_code), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Framing stage between the PC-side `uart_controller8bit` receive port and the BlueTooth request FIFO write port. It consumes raw received bytes and hunts for frames of the form header, LEN, LEN payload bytes, checksum. It buffers each payload internally and forwards it only after the checksum passes. Corrupt, oversized or stalled frames are dropped and reported, so only whole validated commands reach the BlueTooth controller.

## Interface
- `HEADER`, 8'hA5, frame start byte.
- `MAX_LEN`, 16, maximum payload length; legal range 1..255.
- `TIMEOUT_CYC`, 50000, maximum idle clocks between bytes inside a frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte; valid while `rx_rdy`=1.
- `rx_rdy`  in  1  byte available; held by the UART until acknowledged.
- `rx_ack`  out  1  one-cycle pulse: byte consumed.
- `out_data`  out  8  payload byte to the request FIFO.
- `out_vld`  out  1  `out_data` valid.
- `out_rdy`  in  1  FIFO accepts; a transfer occurs on `out_vld`&&`out_rdy`.
- `frame_ok`  out  1  one-cycle pulse: checksum passed.
- `frame_err`  out  1  one-cycle pulse: frame dropped.
- `err_code`  out  2  last error: 01 bad LEN, 10 checksum mismatch, 11 timeout; holds until the next error.
- `busy`  out  1  high in every state except S_HUNT.

## Operation
- Reset values: all outputs 0; state S_HUNT; buffer contents don't-care.
- Byte consume rule:
  - A byte is consumed on a cycle with `rx_rdy`=1, state≠S_DRAIN, and not inside the 2-cycle guard window.
  - `rx_ack`=1 on the following cycle. The guard window is the ack cycle plus one cycle after it; no byte is consumed in it.
- S_HUNT: a consumed byte ≠`HEADER` is discarded silently. A byte =`HEADER` moves to S_LEN.
- S_LEN: LEN is consumed.
  - LEN=0 or LEN>`MAX_LEN`: `frame_err`, `err_code`=01, go to S_HUNT.
  - Otherwise: csum←LEN, count←0, go to S_PAYLOAD.
- S_PAYLOAD: each consumed byte is written to buf[count]; csum←csum+byte (mod 256); count++. After the LEN-th byte, go to S_CSUM.
- S_CSUM: the consumed byte is compared with csum.
  - Equal: `frame_ok`, rd_ptr←0, go to S_DRAIN.
  - Not equal: `frame_err`, `err_code`=10, go to S_HUNT.
- S_DRAIN: `out_vld`=1 and `out_data`=buf[rd_ptr], both driven from registers only.
  - Each transfer increments rd_ptr.
  - After the transfer of byte LEN-1, go to S_HUNT with `out_vld`=0 on the next cycle.
  - No rx bytes are consumed; the UART is back-pressured.
- Timeout:
  - The idle counter clears on every consumed byte and counts in S_LEN, S_PAYLOAD and S_CSUM only.
  - On reaching `TIMEOUT_CYC` with no byte: `frame_err`, `err_code`=11, go to S_HUNT.
  - A byte consumed on the same cycle wins over the timeout.
- Width rules:
  - count and rd_ptr: $clog2(`MAX_LEN`+1) bits.
  - Idle counter: $clog2(`TIMEOUT_CYC`+1) bits, saturating.
  - csum: 8 bits, wraps.
- `HEADER` inside the payload or in the checksum position is ordinary data; no resync occurs.

## Timing
- Byte consumed at cycle T: `rx_ack` high at T+1 only. The next consume is possible at T+3 at the earliest.
- Checksum byte consumed at T:
  - Pass: `frame_ok` at T+1 and `out_vld` at T+1.
  - Fail: `frame_err` and `err_code` updated at T+1.
- Drain throughput is 1 byte/cycle while `out_rdy`=1. `out_data` is stable while `out_vld`=1 and `out_rdy`=0.
- Timeout: `frame_err` asserts `TIMEOUT_CYC` cycles after the cycle of the last consumed byte.
- `rst_n` low at any time, including mid-frame or mid-drain:
  - All outputs drop to 0 immediately (asynchronously).
  - The partial frame is lost.
  - No `frame_err` pulse is generated.

## Test plan
- Bytes A5 03 11 22 33 69, `out_rdy`=1 → `frame_ok` once; `out_data` 11, 22, 33 on consecutive cycles; 6 `rx_ack` pulses.
- Bytes 00 FF A5 01 7E 7F → 00 and FF acked and dropped; single output byte 7E; `frame_ok`.
- Bytes A5 03 11 22 33 6A → `frame_err`, `err_code`=10, no `out_vld`. A following valid frame is then parsed normally.
- A5 00, and separately A5 11 (with `MAX_LEN`=16) → `frame_err`, `err_code`=01, return to S_HUNT after the LEN byte.
- `TIMEOUT_CYC`=100; bytes A5 02 11, then silence → `frame_err` with `err_code`=11 exactly 100 cycles after byte 11 is consumed; `busy`=0 afterwards.
- Two back-to-back valid frames, `out_rdy` low for 10 cycles mid-drain, with `rx_rdy` held high carrying A5 → `out_data` held, no `rx_ack` until the drain ends, then the second frame parses. Then assert `rst_n`=0 mid-drain → all outputs 0 and the design is in S_HUNT.
